// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file with pending-write scoreboard.
// Provides default sizes, the address-width helper and the busy-vector type.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    // Address width for a register count; never narrower than one bit.
    function automatic int aw_of(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef logic [NREGS_DEF-1:0] busy_vec_t;

endpackage

// File: rtl/regfile_busy_table.sv
// Pending-write scoreboard: one busy bit per register, issue acceptance and busy count.
// Ports: clk, rst_n, we/wa (writeback clear), iss_valid/iss_rd/iss_ready (issue set), busy, nbusy.
module regfile_busy_table #(
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_rd,
    output logic             iss_ready,
    output logic [NREGS-1:0] busy,
    output logic [AW:0]      nbusy
);

    localparam logic ZR = (ZERO_REG != 0);

    logic zr_iss;
    logic zr_wa;
    logic set;
    logic clr;
    logic inc;
    logic dec;

    assign zr_iss = ZR && (iss_rd == '0);
    assign zr_wa  = ZR && (wa == '0);

    // A writeback to the same register this cycle resolves the WAW hazard.
    assign iss_ready = !iss_valid || zr_iss || !busy[iss_rd]
                     || (we && (wa == iss_rd));

    assign set = iss_valid && iss_ready && !zr_iss;
    assign clr = we && !zr_wa;

    // Count changes only when a bit actually flips; a set and clear on
    // the same register leaves it busy, so no decrement then.
    assign inc = set && !busy[iss_rd];
    assign dec = clr && busy[wa] && !(set && (wa == iss_rd));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= '0;
            nbusy <= '0;
        end else begin
            if (clr) busy[wa] <= 1'b0;
            // Later assignment wins: set overrides a same-register clear.
            if (set) busy[iss_rd] <= 1'b1;
            nbusy <= nbusy + (AW+1)'(inc) - (AW+1)'(dec);
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with write-through bypass, zero register and scoreboard.
// Ports: rd_addr/rd_data/rd_busy per read port, we/wa/wd writeback, iss_* issue, nbusy count.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    localparam int AW      = aw_of(NREGS),
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    output logic                iss_ready,
    output logic [AW:0]         nbusy
);

    localparam logic ZR  = (ZERO_REG != 0);
    localparam logic BYP = (BYPASS != 0);

    logic [XLEN-1:0]  mem [NREGS];
    logic [NREGS-1:0] busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (we && !(ZR && (wa == '0))) begin
            mem[wa] <= wd;
        end
    end

    regfile_busy_table #(
        .NREGS    (NREGS),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_busy (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .wa        (wa),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .busy      (busy),
        .nbusy     (nbusy)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        logic            b;

        assign a = rd_addr[i*AW +: AW];

        always_comb begin
            d = mem[a];
            b = busy[a];
            if (ZR && (a == '0)) begin
                d = '0;
                b = 1'b0;
            end else if (BYP && we && (wa == a)) begin
                d = wd;
                b = 1'b0;
            end
        end

        assign rd_data[i*XLEN +: XLEN] = d;
        assign rd_busy[i]              = b;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed scoreboard bench for regfile_scoreboard, bypass and non-bypass builds.
// Expected values are queued at drive time and popped when the DUT output is sampled.
module tb_regfile_scoreboard;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NRD*AW-1:0]   rd_addr;
    logic                we;
    logic [AW-1:0]       wa;
    logic [XLEN-1:0]     wd;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;

    logic [NRD*XLEN-1:0] a_data, b_data;
    logic [NRD-1:0]      a_busy, b_busy;
    logic                a_ready, b_ready;
    logic [AW:0]         a_nbusy, b_nbusy;

    always #5 clk = ~clk;

    regfile_scoreboard #(.BYPASS(1)) u_a (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(a_data),
        .rd_busy(a_busy), .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid),
        .iss_rd(iss_rd), .iss_ready(a_ready), .nbusy(a_nbusy)
    );

    regfile_scoreboard #(.BYPASS(0)) u_b (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(b_data),
        .rd_busy(b_busy), .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid),
        .iss_rd(iss_rd), .iss_ready(b_ready), .nbusy(b_nbusy)
    );

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        q.push_back(e);
    endtask

    task automatic pop_check(input logic [63:0] obs);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $error("FAIL queue_empty observed=%h required=<entry>", obs);
        end else begin
            e = q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h required=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; rd_addr = '0; we = 1'b0; wa = '0; wd = '0;
        iss_valid = 1'b0; iss_rd = '0;
        #1;
        push("rst_nbusy", 64'd0);
        pop_check(64'(a_nbusy));
        step(); step();
        rst_n = 1'b1;

        // Reset contents on every address and port.
        for (int a = 0; a < NREGS; a++) begin
            step();
            rd_addr = {AW'(a), AW'(a)};
            #1;
            push($sformatf("rst_data_%0d", a), 64'd0);
            pop_check(a_data);
            push($sformatf("rst_busy_%0d", a), 64'd0);
            pop_check(64'({a_busy, b_busy}));
        end
        push("rst_ready", 64'd1);
        pop_check(64'(a_ready));
        push("rst_nbusy2", 64'd0);
        pop_check(64'(a_nbusy));

        // Same-cycle write-through vs. registered read.
        step();
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; rd_addr = {5'd0, 5'd5};
        #1;
        push("byp_same", 64'hDEADBEEF);
        pop_check(64'(a_data[31:0]));
        push("nobyp_same", 64'd0);
        push("nobyp_next", 64'hDEADBEEF);
        pop_check(64'(b_data[31:0]));
        step();
        we = 1'b0;
        #1;
        pop_check(64'(b_data[31:0]));
        push("byp_next", 64'hDEADBEEF);
        pop_check(64'(a_data[31:0]));

        // Zero register ignores writes and never goes busy.
        step();
        we = 1'b1; wa = 5'd0; wd = 32'h1234; rd_addr = {5'd0, 5'd0};
        #1;
        push("zero_wr_same", 64'd0);
        pop_check(64'(a_data[31:0]));
        step();
        we = 1'b0; iss_valid = 1'b1; iss_rd = 5'd0;
        #1;
        push("zero_rd", 64'd0);
        pop_check(64'({a_data[31:0], b_data[31:0]}));
        push("zero_iss_ready", 64'd1);
        pop_check(64'(a_ready));
        step();
        iss_valid = 1'b0;
        #1;
        push("zero_nbusy", 64'd0);
        pop_check(64'(a_nbusy));

        // WAW conflict on register 7, then release by writeback.
        step();
        iss_valid = 1'b1; iss_rd = 5'd7; rd_addr = {5'd0, 5'd7};
        #1;
        push("iss7_first", 64'd1);
        pop_check(64'(a_ready));
        step();
        #1;
        push("iss7_again", 64'd0);
        pop_check(64'({a_ready, b_ready}));
        push("busy7", 64'd1);
        pop_check(64'(a_busy[0]));
        push("nbusy7", 64'd1);
        pop_check(64'(a_nbusy));
        step();
        we = 1'b1; wa = 5'd7; wd = 32'd77;
        #1;
        push("iss7_wb_ready", 64'd3);
        pop_check(64'({a_ready, b_ready}));
        push("busy7_wb_byp", 64'd0);
        pop_check(64'(a_busy[0]));
        push("busy7_wb_nobyp", 64'd1);
        pop_check(64'(b_busy[0]));
        step();
        we = 1'b0; iss_valid = 1'b0;
        #1;
        push("busy7_kept", 64'd1);
        pop_check(64'({a_busy[0], b_busy[0]} == 2'b11));
        push("nbusy7_kept", 64'd1);
        pop_check(64'(a_nbusy));
        push("data7", 64'd77);
        pop_check(64'(a_data[31:0]));
        step();
        we = 1'b1; wa = 5'd7; wd = 32'd78;
        step();
        we = 1'b0;
        #1;
        push("nbusy7_clear", 64'd0);
        pop_check(64'(b_nbusy));

        // Fill every writable register, then drain.
        for (int r = 1; r < NREGS; r++) begin
            step();
            iss_valid = 1'b1; iss_rd = AW'(r);
            #1;
            push($sformatf("fill_ready_%0d", r), 64'd1);
            pop_check(64'(a_ready));
        end
        step();
        iss_valid = 1'b0;
        #1;
        push("nbusy_full", 64'd31);
        pop_check(64'(a_nbusy));
        push("nbusy_full_b", 64'd31);
        pop_check(64'(b_nbusy));
        for (int r = 1; r < NREGS; r++) begin
            step();
            we = 1'b1; wa = AW'(r); wd = 32'(r * 3);
        end
        step();
        we = 1'b0; rd_addr = {5'd31, 5'd9};
        #1;
        push("nbusy_drained", 64'd0);
        pop_check(64'(a_nbusy));
        push("drain_data", {32'd93, 32'd27});
        pop_check(a_data);

        // Asynchronous reset mid-sequence drops all pending state.
        for (int r = 1; r <= 10; r++) begin
            step();
            iss_valid = 1'b1; iss_rd = AW'(r);
        end
        step();
        iss_valid = 1'b0; rd_addr = {5'd3, 5'd9};
        #1;
        push("nbusy_ten", 64'd10);
        pop_check(64'(a_nbusy));
        #1;
        rst_n = 1'b0;
        #1;
        push("async_nbusy", 64'd0);
        pop_check(64'({a_nbusy, b_nbusy}));
        push("async_busy", 64'd0);
        pop_check(64'({a_busy, b_busy}));
        push("async_data", 64'd0);
        pop_check(a_data);
        step();
        rst_n = 1'b1;

        if (q.size() != 0) begin
            errors++;
            $error("FAIL queue_leftover observed=%0d required=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
